bit_scan_counter: RTL and testbench
===================================

# bit_scan_counter

Parametrised multi-mode successor to the single-width bit counter. It counts ones, zeros, trailing zeros or leading zeros of a WIDTH-bit operand. The algorithm is sequential, one bit per clock, and exits early when no bits of interest remain. It uses the same level-sensitive start/done handshake as the board-level bit counter, so top-level wrappers (synchronizers, seg7 display) attach unchanged.

## Interface
- WIDTH, default 8: operand width; legal range WIDTH ≥ 2.
- RW, default $clog2(WIDTH+1): result width; a derived localparam, never overridden.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- start  input  1  level-sensitive request; sampled only in IDLE and DONE.
- mode  input  2  2'b00 = ones count, 01 = zeros count, 10 = trailing zeros, 11 = leading zeros.
- in  input  WIDTH  operand.
- busy  output  1  high while state is RUN.
- done  output  1  high while state is DONE.
- result  output  RW  count; valid while done = 1.

## Operation
- Internal registers:
  - state: IDLE, RUN or DONE.
  - A: WIDTH-bit shift register.
  - mode_r: 2-bit latched mode.
  - steps: RW-bit counter of processed bits.
  - result: RW-bit count.
- Reset values: state = IDLE, A = 0, mode_r = 0, steps = 0, result = 0, busy = 0, done = 0.
- IDLE, start = 1 → RUN, with the following loads on the same edge:
  - mode_r ← mode.
  - result ← 0 and steps ← 0.
  - A ← in for modes 00 and 10; A ← ~in for mode 01; A ← bit-reverse(in) for mode 11 (in[WIDTH-1] goes to A[0]).
- IDLE, start = 0: stay in IDLE; all registers hold.
- RUN: the termination test is evaluated on the current register values each cycle.
  - Modes 00/01: terminate when A == 0. Otherwise result ← result + A[0], A ← A >> 1, steps ← steps + 1.
  - Modes 10/11: terminate when A[0] == 1 or steps == WIDTH. Otherwise result ← result + 1, A ← A >> 1, steps ← steps + 1.
  - On termination: → DONE; result, A and steps hold.
- DONE, start = 1: hold; result stays stable.
- DONE, start = 0: → IDLE. result holds until the next load.
- in and mode are ignored outside the loading edge. Changes during RUN or DONE have no effect.
- Dropping start during RUN does not abort the computation. RUN completes, enters DONE for exactly one cycle, then returns to IDLE.
- Reset asserted at any time, including mid-RUN: immediate return to the reset state. The partial result is discarded.
- Arithmetic:
  - result never exceeds WIDTH, so RW bits are sufficient and no wrap-around is possible.
  - A shifts in zeros at its MSB.
  - An all-zero in yields: mode 00 → 0; mode 01 → WIDTH; mode 10 → WIDTH; mode 11 → WIDTH.

## Timing
- Let edge k be the edge at which start is sampled high in IDLE.
- Let N = number of bits processed:
  - Modes 00/01: N = index of the highest set bit of the loaded A, plus 1; N = 0 if the loaded A == 0.
  - Modes 10/11: N = number of trailing zeros of the loaded A, capped at WIDTH.
- busy is high from after edge k through edge k+N+1.
- done rises after edge k+N+1: the latency is N+2 cycles. The minimum latency is 2 cycles (N = 0); the maximum is WIDTH+2.
- done falls one edge after start is sampled low in DONE.
- A new start may be accepted at the earliest 1 cycle after done falls.
- busy and done are Moore outputs, decoded from state only. They are never high simultaneously.
- result changes only on the loading edge and on RUN edges, never while done = 1.

## Test plan
- Reset mid-RUN: WIDTH = 8, mode 00, in = 8'hFF, start = 1; assert reset 3 cycles after start is sampled → busy = 0, done = 0 and result = 0 without waiting for a clock edge; after release the block stays in IDLE until start is sampled again.
- Mode 00, in = 8'b0001_0100, start held high → result = 2, done rises 7 cycles after the sampling edge (N = 5); start = 0 → done low the next cycle and result still reads 2.
- Zero operand, WIDTH = 8, in = 8'h00, all four modes → results 0, 8, 8, 8 with latencies 2, 10, 10, 10.
- Modes 10 and 11, in = 8'b0001_0100 → trailing zeros = 2 (latency 4); leading zeros = 3 (latency 5).
- Start dropped during RUN and operand changes: mode 01, in = 8'h0F; drop start one cycle after it is sampled and change in/mode during RUN → result = 4, done is high for exactly one cycle, and the changes have no effect.
- Parametrisation, WIDTH = 13, mode 00: in = all ones → result = 13 (RW = 4), latency 15; back-to-back runs each reload result from 0.

Source files
------------

// File: rtl/bit_scan_counter.sv
// bit_scan_counter
//
// Sequential bit scanner. It processes one operand bit per clock and stops
// early once no bits of interest remain. Four modes:
//   2'b00 ones count      2'b01 zeros count
//   2'b10 trailing zeros  2'b11 leading zeros
// Handshake: start is a level request. It is sampled only in IDLE and DONE.
// done stays high until start is seen low, so a slow requester cannot miss it.
//
// Ports:
//   clk     system clock, rising-edge active
//   reset   asynchronous, active-high reset
//   start   level-sensitive request
//   mode    scan mode, latched on the loading edge
//   in      WIDTH-bit operand, sampled on the loading edge only
//   busy    high while the scan is running
//   done    high while the result is presented
//   result  RW-bit count, valid while done is high
module bit_scan_counter #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned RW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    result
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ModeOnes  = 2'b00,
    ModeZeros = 2'b01,
    ModeTrail = 2'b10,
    ModeLead  = 2'b11
  } mode_e;

  // Position scans stop at the first one or after WIDTH steps.
  localparam logic [RW-1:0] StepsMax = RW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       mode_q, mode_d;
  logic [RW-1:0]    steps_q, steps_d;
  logic [RW-1:0]    result_q, result_d;

  logic [WIDTH-1:0] in_rev;
  logic [WIDTH-1:0] load_value;
  logic             pos_scan;
  logic             terminate;
  logic [RW-1:0]    increment;

  // Leading zeros are counted as trailing zeros of the mirrored operand.
  always_comb begin
    in_rev = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      in_rev[i] = in[int'(WIDTH) - 1 - i];
    end
  end

  // Every mode is reduced to a question about A[0] while A shifts right.
  // Zeros are counted as ones of the complement.
  always_comb begin
    load_value = in;
    unique case (mode)
      ModeOnes:  load_value = in;
      ModeZeros: load_value = ~in;
      ModeTrail: load_value = in;
      ModeLead:  load_value = in_rev;
      default:   load_value = in;
    endcase
  end

  // mode_q[1] selects the position scans (trailing/leading zeros).
  assign pos_scan = mode_q[1];

  always_comb begin
    if (pos_scan) begin
      terminate = a_q[0] || (steps_q == StepsMax);
    end else begin
      terminate = (a_q == '0);
    end
  end

  always_comb begin
    increment    = '0;
    increment[0] = pos_scan ? 1'b1 : a_q[0];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    mode_d   = mode_q;
    steps_d  = steps_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          mode_d   = mode;
          a_d      = load_value;
          steps_d  = '0;
          result_d = '0;
        end
      end

      StRun: begin
        // The scan finishes even if start drops; the requester only sees done.
        if (terminate) begin
          state_d = StDone;
        end else begin
          result_d = result_q + increment;
          a_d      = a_q >> 1;
          steps_d  = steps_q + 1'b1;
        end
      end

      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      mode_q   <= '0;
      steps_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      mode_q   <= mode_d;
      steps_q  <= steps_d;
      result_q <= result_d;
    end
  end

  // Moore outputs, decoded from state only
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = result_q;

`ifndef SYNTHESIS
  busy_done_exclusive_a : assert property (@(posedge clk) disable iff (reset)
    !(busy && done));

  result_in_range_a : assert property (@(posedge clk) disable iff (reset)
    result <= StepsMax);

  result_stable_while_done_a : assert property (@(posedge clk) disable iff (reset)
    (done && start) |=> $stable(result));
`endif

endmodule

// File: tb/tb_bit_scan_counter.sv
module tb_bit_scan_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start8 = 1'b0;
  logic [1:0]  mode8 = 2'b00;
  logic [7:0]  in8 = '0;
  logic        busy8, done8;
  logic [3:0]  res8;

  logic        start13 = 1'b0;
  logic [1:0]  mode13 = 2'b00;
  logic [12:0] in13 = '0;
  logic        busy13, done13;
  logic [3:0]  res13;

  typedef struct {
    int res;
    int lat;
    int start_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q13[$];
  exp_t e8, e13;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic done8_prev = 1'b0;
  logic done13_prev = 1'b0;

  always #5 clk = ~clk;

  bit_scan_counter #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .reset  (reset),
    .start  (start8),
    .mode   (mode8),
    .in     (in8),
    .busy   (busy8),
    .done   (done8),
    .result (res8)
  );

  bit_scan_counter #(.WIDTH(13)) u_dut13 (
    .clk    (clk),
    .reset  (reset),
    .start  (start13),
    .mode   (mode13),
    .in     (in13),
    .busy   (busy13),
    .done   (done13),
    .result (res13)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: result and number of processed bits N.
  function automatic void model(input int w, input logic [1:0] m, input logic [12:0] v,
                                output int res, output int n);
    res = 0;
    n   = 0;
    case (m)
      2'b00: for (int i = 0; i < w; i++) if (v[i]) begin res++; n = i + 1; end
      2'b01: for (int i = 0; i < w; i++) if (!v[i]) begin res++; n = i + 1; end
      2'b10: begin
        for (int i = 0; i < w; i++) begin
          if (v[i]) break;
          res++;
        end
        n = res;
      end
      default: begin
        for (int i = w - 1; i >= 0; i--) begin
          if (v[i]) break;
          res++;
        end
        n = res;
      end
    endcase
  endfunction

  // Scoreboard: pop an expectation on every rising done.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (done8 && !done8_prev) begin
      if (q8.size() == 0) begin
        check("done8_unexpected", 1, 0);
      end else begin
        e8 = q8.pop_front();
        check("result8", 32'(res8), e8.res);
        check("latency8", cyc - e8.start_cyc + 1, e8.lat);
      end
    end
    done8_prev = done8;
    if (done13 && !done13_prev) begin
      if (q13.size() == 0) begin
        check("done13_unexpected", 1, 0);
      end else begin
        e13 = q13.pop_front();
        check("result13", 32'(res13), e13.res);
        check("latency13", cyc - e13.start_cyc + 1, e13.lat);
      end
    end
    done13_prev = done13;
  end

  // One full handshake; hold = extra cycles start stays high in DONE.
  task automatic op(input bit wide, input logic [1:0] m, input logic [12:0] v,
                    input int exp_res, input int exp_lat, input int hold);
    exp_t item;
    int   n;
    @(negedge clk);
    item.res       = exp_res;
    item.lat       = exp_lat;
    item.start_cyc = cyc + 1;
    if (wide) begin
      mode13 = m; in13 = v; start13 = 1'b1;
      q13.push_back(item);
    end else begin
      mode8 = m; in8 = v[7:0]; start8 = 1'b1;
      q8.push_back(item);
    end
    n = 0;
    while (!(wide ? done13 : done8) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(wide ? done13 : done8), 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_held", 32'(wide ? done13 : done8), 1);
      check("result_held", 32'(wide ? res13 : res8), exp_res);
    end
    if (wide) start13 = 1'b0; else start8 = 1'b0;
    @(negedge clk);
    check("done_fall", 32'(wide ? done13 : done8), 0);
    check("result_after", 32'(wide ? res13 : res8), exp_res);
  endtask

  initial begin
    int r, n, m;
    logic [12:0] v;
    int wait_n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_result", 32'(res8), 0);
    reset = 1'b0;

    // Reset mid-RUN acts without a clock edge
    @(negedge clk);
    mode8 = 2'b00; in8 = 8'hFF; start8 = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", 32'(busy8), 1);
    reset = 1'b1;
    #1;
    check("midrun_busy", 32'(busy8), 0);
    check("midrun_done", 32'(done8), 0);
    check("midrun_result", 32'(res8), 0);
    start8 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 32'(busy8), 0);
      check("idle_done", 32'(done8), 0);
    end

    // Ones count, start held in DONE
    op(0, 2'b00, 13'h14, 2, 7, 2);

    // Zero operand, all modes
    op(0, 2'b00, 13'h00, 0, 2, 0);
    op(0, 2'b01, 13'h00, 8, 10, 0);
    op(0, 2'b10, 13'h00, 8, 10, 0);
    op(0, 2'b11, 13'h00, 8, 10, 1);

    // Trailing / leading zeros
    op(0, 2'b10, 13'h14, 2, 4, 0);
    op(0, 2'b11, 13'h14, 3, 5, 0);

    // Start dropped during RUN while operand and mode change
    begin
      exp_t item;
      @(negedge clk);
      item.res = 4; item.lat = 10; item.start_cyc = cyc + 1;
      mode8 = 2'b01; in8 = 8'h0F; start8 = 1'b1;
      q8.push_back(item);
      @(negedge clk);
      start8 = 1'b0; in8 = 8'hF0; mode8 = 2'b10;
      @(negedge clk);
      in8 = 8'h33; mode8 = 2'b00;
      wait_n = 0;
      while (!done8 && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
      end
      check("drop_done_seen", 32'(done8), 1);
      @(negedge clk);
      check("drop_done_one_cycle", 32'(done8), 0);
      check("drop_result", 32'(res8), 4);
      repeat (2) begin
        @(negedge clk);
        check("drop_no_restart", 32'(busy8 | done8), 0);
      end
    end

    // Random operands against the model
    for (int i = 0; i < 8; i++) begin
      m = $urandom_range(0, 3);
      v = 13'($urandom_range(0, 255));
      model(8, m[1:0], v, r, n);
      op(0, m[1:0], v, r, n + 2, i % 2);
    end

    // WIDTH = 13, back-to-back
    op(1, 2'b00, 13'h1FFF, 13, 15, 0);
    op(1, 2'b00, 13'h0005, 2, 5, 0);
    op(1, 2'b00, 13'h1FFF, 13, 15, 0);
    model(13, 2'b11, 13'h0040, r, n);
    op(1, 2'b11, 13'h0040, r, n + 2, 0);

    repeat (2) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q13_drained", q13.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
